// File: rtl/lock_key_loader_if.sv
// Bit-serial key link between a key source (fuse/OTP reader, test host) and the loader.
// Handshake: a bit transfers on a rising edge where key_bit_valid and key_bit_ready are both high;
// load_start is a one-cycle request that (re)starts a load and is not subject to ready.
interface lock_key_loader_if;
  logic load_start;
  logic key_bit;
  logic key_bit_valid;
  logic key_bit_ready;

  modport master (
    output load_start,
    output key_bit,
    output key_bit_valid,
    input  key_bit_ready
  );

  modport slave (
    input  load_start,
    input  key_bit,
    input  key_bit_valid,
    output key_bit_ready
  );
endinterface

// File: rtl/lock_key_loader.sv
// Serial key loader for a logic-locked core: stages key bits in a shadow register, commits them
// atomically to k, and masks the core outputs until a complete key is in place.
module lock_key_loader #(
  parameter int KEY_W   = 3,
  parameter int OUT_W   = 7,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  lock_key_loader_if.slave   kif,
  output logic [KEY_W-1:0]   k,
  output logic               key_loaded,
  output logic               busy,
  output logic               err,
  input  logic [OUT_W-1:0]   lock_out,
  output logic [OUT_W-1:0]   prot_out,
  output logic [1:0]         dbg_state_o
);

  localparam int CNT_W  = $clog2(KEY_W + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(KEY_W - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t              state_q;
  logic [KEY_W-1:0]    k_q;
  logic [KEY_W-1:0]    shadow_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [IDLE_W-1:0]   idle_q;
  logic                loaded_q;
  logic                err_q;
  logic [OUT_W-1:0]    prot_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      k_q      <= '1;
      shadow_q <= '0;
      cnt_q    <= '0;
      idle_q   <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
      prot_q   <= '0;
    end else begin
      err_q  <= 1'b0;
      prot_q <= loaded_q ? lock_out : '0;
      case (state_q)
        ST_IDLE: begin
          if (kif.load_start) begin
            state_q  <= ST_SHIFT;
            shadow_q <= '0;
            cnt_q    <= '0;
            idle_q   <= '0;
            loaded_q <= 1'b0;
          end
        end
        ST_SHIFT: begin
          // A restart wins over a bit presented in the same cycle; that bit is dropped.
          if (kif.load_start) begin
            shadow_q <= '0;
            cnt_q    <= '0;
            idle_q   <= '0;
            err_q    <= 1'b1;
          end else if (kif.key_bit_valid) begin
            shadow_q <= shadow_q | (KEY_W'(kif.key_bit) << cnt_q);
            cnt_q    <= cnt_q + CNT_W'(1);
            idle_q   <= '0;
            if (cnt_q == CNT_LAST) state_q <= ST_COMMIT;
          end else if (idle_q == IDLE_LAST) begin
            state_q <= ST_IDLE;
            idle_q  <= '0;
            err_q   <= 1'b1;
          end else begin
            idle_q <= idle_q + IDLE_W'(1);
          end
        end
        ST_COMMIT: begin
          k_q      <= shadow_q;
          loaded_q <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign kif.key_bit_ready = (state_q == ST_SHIFT);
  assign busy              = (state_q == ST_SHIFT) || (state_q == ST_COMMIT);
  assign k                 = k_q;
  assign key_loaded        = loaded_q;
  assign err               = err_q;
  assign prot_out          = prot_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_lock_key_loader.sv
// Directed bench for lock_key_loader: reset, back-to-back and gapped loads, timeout,
// restart abort, load_start during COMMIT, and reset in the middle of a load.
module tb_lock_key_loader;
  localparam int KEY_W   = 3;
  localparam int OUT_W   = 7;
  localparam int TIMEOUT = 16;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic             clk;
  logic             rst;
  logic [KEY_W-1:0] k;
  logic             key_loaded;
  logic             busy;
  logic             err;
  logic [OUT_W-1:0] lock_out;
  logic [OUT_W-1:0] prot_out;
  logic [1:0]       dbg_state;

  int n_vec;
  int n_fail;

  lock_key_loader_if kif ();

  lock_key_loader #(.KEY_W(KEY_W), .OUT_W(OUT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .kif         (kif),
    .k           (k),
    .key_loaded  (key_loaded),
    .busy        (busy),
    .err         (err),
    .lock_out    (lock_out),
    .prot_out    (prot_out),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // full back-to-back load of key (LSB first), ending one tick after COMMIT
  task automatic load_key(input logic [KEY_W-1:0] key);
    kif.load_start = 1'b1;
    tick();
    kif.load_start = 1'b0;
    for (int i = 0; i < KEY_W; i++) begin
      kif.key_bit       = key[i];
      kif.key_bit_valid = 1'b1;
      tick();
    end
    kif.key_bit_valid = 1'b0;
    kif.key_bit       = 1'b0;
    tick();
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    rst               = 1'b1;
    kif.load_start    = 1'b0;
    kif.key_bit       = 1'b0;
    kif.key_bit_valid = 1'b0;
    lock_out          = '0;

    // 1: reset
    tick();
    tick();
    rst = 1'b0;
    check("rst_k", k, 3'b111);
    check("rst_key_loaded", key_loaded, 0);
    check("rst_prot_out", prot_out, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", kif.key_bit_ready, 0);
    check("rst_state", dbg_state, S_IDLE);

    // 2: load 000 back-to-back, key_loaded 5 edges after load_start
    lock_out       = 7'h55;
    kif.load_start = 1'b1;
    tick();
    kif.load_start = 1'b0;
    check("t2_state_shift", dbg_state, S_SHIFT);
    check("t2_ready0", kif.key_bit_ready, 1);
    check("t2_busy", busy, 1);
    kif.key_bit       = 1'b0;
    kif.key_bit_valid = 1'b1;
    tick();
    check("t2_ready1", kif.key_bit_ready, 1);
    tick();
    check("t2_ready2", kif.key_bit_ready, 1);
    tick();
    kif.key_bit_valid = 1'b0;
    check("t2_state_commit", dbg_state, S_COMMIT);
    check("t2_ready_commit", kif.key_bit_ready, 0);
    check("t2_busy_commit", busy, 1);
    check("t2_k_not_yet", k, 3'b111);
    check("t2_loaded_not_yet", key_loaded, 0);
    tick();
    check("t2_k", k, 3'b000);
    check("t2_key_loaded", key_loaded, 1);
    check("t2_busy_idle", busy, 0);
    check("t2_prot_still_gated", prot_out, 0);
    tick();
    check("t2_prot_out", prot_out, 7'h55);

    // 3: load 101 with one valid-low gap
    kif.load_start = 1'b1;
    tick();
    kif.load_start = 1'b0;
    check("t3_loaded_drop", key_loaded, 0);
    check("t3_k_held", k, 3'b000);
    kif.key_bit = 1'b1; kif.key_bit_valid = 1'b1;
    tick();
    kif.key_bit_valid = 1'b0;
    tick();
    check("t3_gap_err", err, 0);
    check("t3_gap_state", dbg_state, S_SHIFT);
    check("t3_prot_gated", prot_out, 0);
    kif.key_bit = 1'b0; kif.key_bit_valid = 1'b1;
    tick();
    kif.key_bit = 1'b1;
    tick();
    kif.key_bit_valid = 1'b0;
    check("t3_state_commit", dbg_state, S_COMMIT);
    tick();
    check("t3_k", k, 3'b101);
    check("t3_key_loaded", key_loaded, 1);
    check("t3_err", err, 0);

    // 4: timeout after 2 bits
    kif.load_start = 1'b1;
    tick();
    kif.load_start = 1'b0;
    kif.key_bit = 1'b0; kif.key_bit_valid = 1'b1;
    tick();
    tick();
    kif.key_bit_valid = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("t4_pre_err", err, 0);
    check("t4_pre_state", dbg_state, S_SHIFT);
    tick();
    check("t4_err", err, 1);
    check("t4_state_idle", dbg_state, S_IDLE);
    check("t4_k_held", k, 3'b101);
    check("t4_key_loaded", key_loaded, 0);
    check("t4_prot_out", prot_out, 0);
    tick();
    check("t4_err_pulse", err, 0);

    // 5: restart after 2 bits with a same-cycle valid bit, then load 1,1,0
    kif.load_start = 1'b1;
    tick();
    kif.load_start = 1'b0;
    kif.key_bit = 1'b1; kif.key_bit_valid = 1'b1;
    tick();
    kif.key_bit = 1'b0;
    tick();
    kif.load_start = 1'b1;
    kif.key_bit    = 1'b1;
    tick();
    kif.load_start = 1'b0;
    check("t5_err", err, 1);
    check("t5_state_shift", dbg_state, S_SHIFT);
    kif.key_bit = 1'b1;
    tick();
    check("t5_err_pulse", err, 0);
    tick();
    check("t5_state_shift2", dbg_state, S_SHIFT);
    kif.key_bit = 1'b0;
    tick();
    kif.key_bit_valid = 1'b0;
    check("t5_state_commit", dbg_state, S_COMMIT);
    check("t5_k_held", k, 3'b101);
    tick();
    check("t5_k", k, 3'b011);
    check("t5_key_loaded", key_loaded, 1);

    // load_start during COMMIT is ignored
    kif.load_start = 1'b1;
    tick();
    kif.load_start = 1'b0;
    kif.key_bit = 1'b0; kif.key_bit_valid = 1'b1;
    tick();
    tick();
    tick();
    kif.key_bit_valid = 1'b0;
    kif.load_start    = 1'b1;
    tick();
    kif.load_start = 1'b0;
    check("commit_ls_state", dbg_state, S_IDLE);
    check("commit_ls_k", k, 3'b000);
    check("commit_ls_loaded", key_loaded, 1);

    // 6: reset mid-SHIFT after a committed 000
    lock_out = 7'h2a;
    load_key(3'b000);
    tick();
    check("t6_prot_live", prot_out, 7'h2a);
    kif.load_start = 1'b1;
    tick();
    kif.load_start = 1'b0;
    kif.key_bit = 1'b1; kif.key_bit_valid = 1'b1;
    tick();
    kif.key_bit_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_k", k, 3'b111);
    check("t6_key_loaded", key_loaded, 0);
    check("t6_prot_out", prot_out, 0);
    check("t6_state", dbg_state, S_IDLE);
    check("t6_busy", busy, 0);
    tick();
    check("t6_prot_after", prot_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
